// File: rtl/scpu_pkg.sv
// Shared types and constants for the single-cycle CPU datapath.
package scpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NPC_OP_W = 2;
  localparam int unsigned J_TGT_W  = 26;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_PC4 = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_t;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    ERR   = 2'b10
  } if_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and memory.
interface if_stage_if;
  import scpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);

endinterface

// File: rtl/if_stage_npc.sv
// Combinational next-PC selection: sequential, branch, jump, jump-register.
module npc
  import scpu_pkg::*;
(
  input  logic [XLEN-1:0]     pc_plus4,
  input  logic [J_TGT_W-1:0]  target,
  input  logic [XLEN-1:0]     ext_imm,
  input  logic [XLEN-1:0]     jr_target,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                branch_taken,
  output logic [XLEN-1:0]     npc
);

  always_comb begin
    npc = pc_plus4;
    case (npc_op_t'(npc_op))
      NPC_BR:  if (branch_taken) npc = pc_plus4 + (ext_imm << 2);
      NPC_J:   npc = {pc_plus4[XLEN-1:XLEN-4], target, 2'b00};
      NPC_JR:  npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch handshake, instruction register and decode fields.
module if_stage
  import scpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  if_stage_if.master          imem,
  output logic                instr_valid,
  input  logic                instr_ack,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     ext_imm,
  input  logic [XLEN-1:0]     jr_target,
  output logic [XLEN-1:0]     instr,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [5:0]          funct,
  output logic [15:0]         imm16,
  output logic [XLEN-1:0]     pc_out,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                pc_err,
  output logic [XLEN-1:0]     retired_cnt
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, instr_q, cnt_q;
  logic            err_q;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            fetch_done, retire;

  npc u_npc (
    .pc_plus4     (pc_plus4),
    .target       (instr_q[J_TGT_W-1:0]),
    .ext_imm      (ext_imm),
    .jr_target    (jr_target),
    .npc_op       (npc_op),
    .branch_taken (branch_taken),
    .npc          (next_pc)
  );

  assign misaligned = |next_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Request is gated by rst so an outstanding fetch is abandoned immediately.
  always_comb begin
    state_d       = state_q;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    fetch_done    = 1'b0;
    retire        = 1'b0;
    case (state_q)
      FETCH: begin
        imem.imem_req = ~rst;
        if (imem.imem_ready) begin
          fetch_done = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          retire  = 1'b1;
          state_d = misaligned ? ERR : FETCH;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (fetch_done) instr_q <= imem.imem_rdata;
      if (retire) begin
        cnt_q <= cnt_q + XLEN'(1);
        if (misaligned) err_q <= 1'b1;
        else            pc_q  <= next_pc;
      end
    end
  end

  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign pc_out         = pc_q;
  assign pc_plus4       = pc_q + XLEN'(4);
  assign pc_err         = err_q;
  assign retired_cnt    = cnt_q;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the single-cycle CPU datapath.
- Owns the PC register and performs a req/ready handshake with instruction memory.
- Holds the fetched word in an instruction register and splits it into fields. imm16 feeds the immediate extender directly.
- Computes the next PC from the control unit's NPC select and the extended immediate it gets back.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the fetch, equal to the PC.
- imem_ready  in  1  imem_rdata valid this cycle; honoured only while imem_req=1.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  the instruction register holds an instruction not yet retired.
- instr_ack  in  1  datapath retires the held instruction; honoured only while instr_valid=1.
- npc_op  in  2  00 PC+4, 01 branch, 10 jump, 11 jump-register.
- branch_taken  in  1  qualifies npc_op=01; if 0, use PC+4.
- ext_imm  in  32  sign-extended offset returned from the extender.
- jr_target  in  32  register value used for npc_op=11.
- instr  out  32  instruction register.
- opcode  out  6  field instr[31:26].
- rs  out  5  field instr[25:21].
- rt  out  5  field instr[20:16].
- rd  out  5  field instr[15:11].
- shamt  out  5  field instr[10:6].
- funct  out  6  field instr[5:0].
- imm16  out  16  field instr[15:0], to the extender.
- pc_out  out  32  PC of the held instruction.
- pc_plus4  out  32  pc_out+4, mod 2^32.
- pc_err  out  1  sticky misaligned-target error.
- retired_cnt  out  32  count of retired instructions.

Behaviour:
- States: FETCH, HOLD, ERR.
- Reset (async, takes effect immediately):
  - state=FETCH, PC=RESET_PC, instr=0, retired_cnt=0, pc_err=0.
  - imem_req drops at once; any outstanding fetch is abandoned.
- FETCH:
  - imem_req=1 and imem_addr=PC; both stay stable until imem_ready.
  - On imem_ready: instr<=imem_rdata, go to HOLD. Zero-wait memory gives a 1-cycle fetch.
- HOLD:
  - instr_valid=1, imem_req=0.
  - Without instr_ack: hold all outputs for any number of cycles (stall).
  - On instr_ack: compute next PC per the selection below and increment retired_cnt (wraps 2^32-1 -> 0).
    - If next PC[1:0]==0: PC<=next PC, go to FETCH.
    - If next PC[1:0]!=0: pc_err<=1, PC unchanged, go to ERR.
- Next-PC selection (combinational, from the held instruction):
  - 00, or 01 with branch_taken=0: pc_plus4.
  - 01 with branch_taken=1: pc_plus4 + (ext_imm<<2), mod 2^32.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: jr_target.
- ERR:
  - imem_req=0, instr_valid=0, instr still held. instr_ack and imem_ready are ignored.
  - The only exit is reset.
- Ignored inputs: imem_ready outside FETCH; instr_ack outside HOLD.
- Throughput: minimum 2 cycles per instruction (FETCH then HOLD); ack and ready never act in the same cycle.
- Decoded fields and pc_plus4 are pure wiring/adders from instr and PC; no extra latency.

Decomposition:
- Shared package scpu_pkg:
  - NPC_PC4/NPC_BR/NPC_J/NPC_JR encodings.
  - if_state_t enum (FETCH/HOLD/ERR).
  - Default RESET_PC constant.
- Sub-module npc: purely combinational next-PC mux/adders. Inputs: pc_plus4, instr[25:0], ext_imm, jr_target, npc_op, branch_taken. Output: 32-bit npc.
- if_stage keeps the FSM, the registers and the counter.

Test Plan:
- Reset, imem_ready=1, rdata 0x2008_0005 -> imem_addr=0x3000 in cycle 1; then instr_valid=1, imm16=0x0005, rt=8, opcode=0x08, pc_plus4=0x3004.
- Stall: hold instr_ack=0 for 5 cycles with imem_ready=1 -> imem_req=0 and instr/pc_out unchanged; ack -> next imem_addr=0x3004, retired_cnt=1.
- Taken branch at PC 0x3000: ext_imm=0xFFFF_FFFF, npc_op=01, branch_taken=1 -> next imem_addr=0x3000. With branch_taken=0 -> 0x3004.
- Jump: instr 0x0800_0C05 at PC 0x3004, npc_op=10 -> imem_addr=0x0000_3014.
- Jump-register to 0x3002 -> pc_err=1, imem_req stays 0, acks ignored; reset -> pc_err=0, imem_addr=0x3000.
- Wait states:
  - imem_ready low for 3 cycles -> imem_req/imem_addr stable throughout.
  - Assert rst mid-wait -> imem_req drops in the same cycle; after release, refetch from 0x3000.
